// File: rtl/sobol_rng_multi.sv
// sobol_rng_multi: NDIM parallel Sobol low-discrepancy sequences that share one step counter.
// The direction index of each step is the trailing-ones count of the counter, which gives Gray-code order.
// Each dimension has its own runtime-programmable direction vectors and a digital-shift seed.
// wrap pulses for one cycle on the step that returns the counter from all-ones to zero.
module sobol_rng_multi #(
    parameter int RWID = 8,
    parameter int NDIM = 4,
    parameter int RWL2 = $clog2(RWID),
    parameter int DWL2 = (NDIM > 1 ? $clog2(NDIM) : 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   restart,
    input  logic                   cfg_dir_we,
    input  logic                   cfg_seed_we,
    input  logic [DWL2-1:0]        cfg_dim,
    input  logic [RWL2-1:0]        cfg_idx,
    input  logic [RWID-1:0]        cfg_data,
    output logic [NDIM*RWID-1:0]   out,
    output logic [RWID-1:0]        cnt,
    output logic                   wrap
);

    logic [RWID-1:0] cnt_q;
    logic            wrap_q;
    logic [RWID-1:0] state_q [NDIM];
    logic [RWID-1:0] seed_q  [NDIM];
    logic [RWID-1:0] dir_q   [NDIM][RWID];

    logic [RWL2-1:0] step_idx;
    logic            cnt_full;
    logic [RWID-1:0] step_vec [NDIM];

    // Direction index for this step: position of the lowest zero bit in the counter.
    // When every bit is one, the step is the period wrap and the index is not used.
    always_comb begin
        step_idx = '0;
        for (int i = RWID - 1; i >= 0; i--) begin
            if (!cnt_q[i]) step_idx = RWL2'(i);
        end
        cnt_full = &cnt_q;
    end

    // Select each dimension's direction vector for the current step index.
    always_comb begin
        for (int d = 0; d < NDIM; d++) begin
            step_vec[d] = '0;
            for (int j = 0; j < RWID; j++) begin
                if (step_idx == RWL2'(j)) step_vec[d] = dir_q[d][j];
            end
        end
    end

    // Step counter and the period-wrap pulse. Restart overrides enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else if (restart) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else if (enable) begin
            cnt_q  <= cnt_q + RWID'(1);
            wrap_q <= cnt_full;
        end else begin
            wrap_q <= 1'b0;
        end
    end

    // Per-dimension Sobol state: XOR in the selected direction vector, or clear on wrap/restart.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < NDIM; d++) state_q[d] <= '0;
        end else if (restart || (enable && cnt_full)) begin
            for (int d = 0; d < NDIM; d++) state_q[d] <= '0;
        end else if (enable) begin
            for (int d = 0; d < NDIM; d++) state_q[d] <= state_q[d] ^ step_vec[d];
        end
    end

    // Digital-shift seeds. A write to a dimension that does not exist matches no entry and is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < NDIM; d++) seed_q[d] <= '0;
        end else begin
            for (int d = 0; d < NDIM; d++) begin
                if (cfg_seed_we && (cfg_dim == DWL2'(d))) seed_q[d] <= cfg_data;
            end
        end
    end

    // Direction vectors reset to van der Corput (1 << (RWID-1-k)) and can be rewritten at runtime.
    // A step in the same cycle as a write reads the old vector, because the write lands at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < NDIM; d++) begin
                for (int j = 0; j < RWID; j++) begin
                    dir_q[d][j] <= RWID'(1) << (RWID - 1 - j);
                end
            end
        end else begin
            for (int d = 0; d < NDIM; d++) begin
                for (int j = 0; j < RWID; j++) begin
                    if (cfg_dir_we && (cfg_dim == DWL2'(d)) && (cfg_idx == RWL2'(j))) begin
                        dir_q[d][j] <= cfg_data;
                    end
                end
            end
        end
    end

    // Output is the registered state digitally shifted by the seed.
    always_comb begin
        for (int d = 0; d < NDIM; d++) begin
            out[d*RWID +: RWID] = state_q[d] ^ seed_q[d];
        end
    end

    assign cnt  = cnt_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_sobol_rng_multi.sv
// Testbench for sobol_rng_multi. NDIM is set to 3, so cfg_dim = 3 is a real out-of-range select.
// The reference model uses the Gray-code view of the Sobol sequence. Each step flips exactly one
// Gray-code bit, and that bit selects the direction vector to XOR into the state.
module tb_sobol_rng_multi;

    localparam int RWID = 8;
    localparam int NDIM = 3;
    localparam int RWL2 = 3;
    localparam int DWL2 = 2;
    localparam int PER  = 1 << RWID;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic                 enable, restart, cfg_dir_we, cfg_seed_we;
    logic [DWL2-1:0]      cfg_dim;
    logic [RWL2-1:0]      cfg_idx;
    logic [RWID-1:0]      cfg_data;
    logic [NDIM*RWID-1:0] dout;
    logic [RWID-1:0]      cnt;
    logic                 wrap;

    sobol_rng_multi #(.RWID(RWID), .NDIM(NDIM)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .restart(restart),
        .cfg_dir_we(cfg_dir_we), .cfg_seed_we(cfg_seed_we), .cfg_dim(cfg_dim),
        .cfg_idx(cfg_idx), .cfg_data(cfg_data), .out(dout), .cnt(cnt), .wrap(wrap)
    );

    // ---------------- reference model ----------------
    logic [RWID-1:0] m_state [NDIM];
    logic [RWID-1:0] m_seed  [NDIM];
    logic [RWID-1:0] m_dir   [NDIM][RWID];
    int              m_cnt;
    logic            m_wrap;

    int n_checks = 0;
    int n_fail   = 0;

    logic [RWID-1:0] exp_q [$];
    bit              seen [NDIM][PER];
    int              steps, wraps, guard, hits, e;
    bit              pre_done;

    function automatic int gray(input int n);
        return n ^ (n >> 1);
    endfunction

    task automatic model_reset();
        m_cnt  = 0;
        m_wrap = 1'b0;
        for (int d = 0; d < NDIM; d++) begin
            m_state[d] = '0;
            m_seed[d]  = '0;
            for (int k = 0; k < RWID; k++) m_dir[d][k] = 8'(1 << (RWID - 1 - k));
        end
    endtask

    // Apply one clock edge to the model using the inputs currently being driven.
    task automatic model_edge();
        int g;
        int k;
        if (restart) begin
            m_cnt  = 0;
            m_wrap = 1'b0;
            for (int d = 0; d < NDIM; d++) m_state[d] = '0;
        end else if (enable) begin
            if (m_cnt == PER - 1) begin
                m_cnt  = 0;
                m_wrap = 1'b1;
                for (int d = 0; d < NDIM; d++) m_state[d] = '0;
            end else begin
                g = gray(m_cnt) ^ gray(m_cnt + 1);
                k = 0;
                for (int b = 0; b < RWID; b++) if (g[b]) k = b;
                for (int d = 0; d < NDIM; d++) m_state[d] = m_state[d] ^ m_dir[d][k];
                m_cnt  = m_cnt + 1;
                m_wrap = 1'b0;
            end
        end else begin
            m_wrap = 1'b0;
        end
        if (int'(cfg_dim) < NDIM) begin
            if (cfg_dir_we)  m_dir[cfg_dim][cfg_idx] = cfg_data;
            if (cfg_seed_we) m_seed[cfg_dim] = cfg_data;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic clear_cfg();
        cfg_dir_we  = 1'b0;
        cfg_seed_we = 1'b0;
        cfg_dim     = '0;
        cfg_idx     = '0;
        cfg_data    = '0;
    endtask

    function automatic logic [RWID-1:0] dim_out(input int d);
        return dout[d*RWID +: RWID];
    endfunction

    // ---------------- scoreboard ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_cnt"}, 32'(cnt), 32'(m_cnt));
        chk({tag, "_wrap"}, 32'(wrap), 32'(m_wrap));
        for (int d = 0; d < NDIM; d++) begin
            chk({tag, "_out"}, 32'(dim_out(d)), 32'(m_state[d] ^ m_seed[d]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        rst_n = 1'b0;
        enable = 1'b0;
        restart = 1'b0;
        clear_cfg();
        model_reset();
        #2;
        check_model("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Default van der Corput sequence, all dimensions identical.
        exp_q = '{8'd128, 8'd192, 8'd64, 8'd96, 8'd224, 8'd160, 8'd32};
        for (int i = 0; i < 7; i++) begin
            enable = 1'b1;
            tick();
            e = int'(exp_q.pop_front());
            for (int d = 0; d < NDIM; d++) begin
                chk("seq_dim", 32'(dim_out(d)), 32'(e));
                seen[d][dim_out(d)] = 1'b1;
            end
            chk("seq_cnt", 32'(cnt), 32'(i + 1));
            check_model("seq");
        end

        // Full period with random enable gaps.
        steps = 7;
        wraps = 0;
        guard = 0;
        pre_done = 1'b0;
        while (steps < PER && guard < 4000) begin
            if (steps == PER - 1 && !pre_done) begin
                chk("pre_wrap_dim0", 32'(dim_out(0)), 32'd1);
                pre_done = 1'b1;
            end
            enable = ($urandom_range(0, 3) != 0);
            tick();
            if (enable) begin
                steps++;
                for (int d = 0; d < NDIM; d++) seen[d][dim_out(d)] = 1'b1;
            end
            if (wrap) wraps++;
            check_model("period");
            guard++;
        end
        chk("period_budget", 32'(steps), 32'(PER));
        chk("wrap_count", 32'(wraps), 32'd1);
        chk("post_wrap_wrap", 32'(wrap), 32'd1);
        chk("post_wrap_cnt", 32'(cnt), 32'd0);
        chk("post_wrap_dim0", 32'(dim_out(0)), 32'd0);
        for (int d = 0; d < NDIM; d++) begin
            hits = 0;
            for (int v = 0; v < PER; v++) hits += int'(seen[d][v]);
            chk("coverage", 32'(hits), 32'(PER));
        end
        enable = 1'b0;
        tick();
        chk("wrap_pulse_end", 32'(wrap), 32'd0);

        // Seed write to dimension 2 mid-run.
        enable = 1'b1;
        repeat (20) begin
            tick();
            check_model("run");
        end
        enable = 1'b0;
        cfg_seed_we = 1'b1;
        cfg_dim = 2'd2;
        cfg_data = 8'h5A;
        tick();
        clear_cfg();
        chk("seed_dim2", 32'(dim_out(2)), 32'(m_state[2] ^ 8'h5A));
        chk("seed_dim0_kept", 32'(dim_out(0)), 32'(m_state[0]));
        check_model("seed");
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("restart_seed_dim2", 32'(dim_out(2)), 32'h5A);
        chk("restart_cnt", 32'(cnt), 32'd0);
        check_model("restart");

        // Direction write during an index-0 step uses the old vector.
        enable = 1'b1;
        cfg_dir_we = 1'b1;
        cfg_dim = 2'd1;
        cfg_idx = 3'd0;
        cfg_data = 8'hFF;
        tick();
        clear_cfg();
        chk("dir_old_vec", 32'(dim_out(1)), 32'h80);
        check_model("dir0");
        tick();
        chk("dir_step1", 32'(dim_out(1)), 32'hC0);
        check_model("dir1");
        tick();
        chk("dir_new_vec", 32'(dim_out(1)), 32'h3F);
        chk("dir_dim0_default", 32'(dim_out(0)), 32'h40);
        check_model("dir2");

        // Enable gaps hold everything.
        enable = 1'b0;
        repeat (3) begin
            tick();
            chk("hold_cnt", 32'(cnt), 32'd3);
            check_model("hold");
        end

        // Restart together with enable at cnt = 37.
        restart = 1'b1;
        tick();
        restart = 1'b0;
        enable = 1'b1;
        repeat (37) begin
            tick();
            check_model("to37");
        end
        chk("cnt37", 32'(cnt), 32'd37);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("rs_en_cnt", 32'(cnt), 32'd0);
        chk("rs_en_wrap", 32'(wrap), 32'd0);
        chk("rs_en_dim2", 32'(dim_out(2)), 32'h5A);
        chk("rs_en_dim0", 32'(dim_out(0)), 32'h00);
        check_model("rs_en");

        // Writes to a nonexistent dimension change nothing.
        enable = 1'b0;
        cfg_dir_we = 1'b1;
        cfg_seed_we = 1'b1;
        cfg_dim = 2'd3;
        cfg_idx = 3'd0;
        cfg_data = 8'hC3;
        tick();
        clear_cfg();
        check_model("oob");
        enable = 1'b1;
        repeat (4) begin
            tick();
            check_model("oob_run");
        end

        // Random mix of steps, restarts and config writes.
        repeat (200) begin
            enable      = ($urandom_range(0, 3) != 0);
            restart     = ($urandom_range(0, 31) == 0);
            cfg_dir_we  = ($urandom_range(0, 3) == 0);
            cfg_seed_we = ($urandom_range(0, 5) == 0);
            cfg_dim     = DWL2'($urandom_range(0, 3));
            cfg_idx     = RWL2'($urandom_range(0, 7));
            cfg_data    = RWID'($urandom_range(0, 255));
            tick();
            check_model("rand");
        end
        clear_cfg();
        restart = 1'b0;

        // Async reset while wrap is high.
        restart = 1'b1;
        tick();
        restart = 1'b0;
        enable = 1'b1;
        repeat (PER) tick();
        check_model("pre_areset");
        chk("pre_areset_wrap", 32'(wrap), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("areset_cnt", 32'(cnt), 32'd0);
        chk("areset_wrap", 32'(wrap), 32'd0);
        for (int d = 0; d < NDIM; d++) chk("areset_out", 32'(dim_out(d)), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q = '{8'd128, 8'd192, 8'd64, 8'd96, 8'd224, 8'd160, 8'd32};
        for (int i = 0; i < 7; i++) begin
            tick();
            e = int'(exp_q.pop_front());
            for (int d = 0; d < NDIM; d++) chk("post_reset_seq", 32'(dim_out(d)), 32'(e));
            check_model("post_reset");
        end
        enable = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
